// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel target and active
// pulse widths. Active widths follow targets only at frame boundaries, keeping pulses glitch-free.
module servo_pwm_multi #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CW         = 20,
    parameter int unsigned PERIOD     = 1_000_000,
    parameter int unsigned PULSE_MIN  = 25_000,
    parameter int unsigned PULSE_MAX  = 125_000,
    parameter int unsigned PULSE_INIT = 75_000,
    parameter int unsigned STEP       = 10_000,
    parameter int unsigned SLEW       = 0,
    localparam int unsigned SW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] enable,
    input  logic [SW-1:0]   sel,
    input  logic            inc,
    input  logic            dec,
    input  logic            wr_en,
    input  logic [CW-1:0]   wr_data,
    output logic [N_CH-1:0] pwm,
    output logic            frame_start,
    output logic            busy,
    output logic [CW-1:0]   rd_width
);

    localparam logic [CW:0]   MIN_W  = (CW + 1)'(PULSE_MIN);
    localparam logic [CW:0]   MAX_W  = (CW + 1)'(PULSE_MAX);
    localparam logic [CW:0]   STEP_W = (CW + 1)'(STEP);
    localparam logic [CW:0]   SLEW_W = (CW + 1)'(SLEW);
    localparam logic [CW-1:0] INIT_V = CW'(PULSE_INIT);
    localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] target_q [N_CH];
    logic [CW-1:0] target_d [N_CH];
    logic [CW-1:0] active_q [N_CH];
    logic [CW-1:0] active_d [N_CH];
    logic [N_CH-1:0] sel_hit;
    logic [CW:0]   cur_t, wr_clamp, inc_sum, inc_val, dec_val, new_t;
    logic          frame_end, strobe, busy_d;
    logic [CW-1:0] rd_d;

    assign frame_end = (count_q == LAST);
    assign strobe    = wr_en | inc | dec;

    // Next target for the selected channel; CW+1 bits so saturation never wraps.
    always_comb begin
        cur_t = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_hit[i] = (sel == SW'(i));
            if (sel_hit[i]) cur_t = {1'b0, target_q[i]};
        end
        if ({1'b0, wr_data} < MIN_W)      wr_clamp = MIN_W;
        else if ({1'b0, wr_data} > MAX_W) wr_clamp = MAX_W;
        else                              wr_clamp = {1'b0, wr_data};
        inc_sum = cur_t + STEP_W;
        inc_val = (inc_sum > MAX_W) ? MAX_W : inc_sum;
        dec_val = (cur_t < MIN_W + STEP_W) ? MIN_W : cur_t - STEP_W;
        if (wr_en)    new_t = wr_clamp;
        else if (inc) new_t = inc_val;
        else          new_t = dec_val;
    end

    // Active widths move at the frame end and see a target written on that same cycle.
    always_comb begin
        logic [CW:0] a, t, diff;
        busy_d = 1'b0;
        rd_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            target_d[i] = (sel_hit[i] && strobe) ? new_t[CW-1:0] : target_q[i];
            a = {1'b0, active_q[i]};
            t = {1'b0, target_d[i]};
            if (SLEW == 0) begin
                diff = '0;
                active_d[i] = target_d[i];
            end else if (t > a) begin
                diff = ((t - a) > SLEW_W) ? SLEW_W : t - a;
                active_d[i] = CW'(a + diff);
            end else begin
                diff = ((a - t) > SLEW_W) ? SLEW_W : a - t;
                active_d[i] = CW'(a - diff);
            end
            if (!frame_end) active_d[i] = active_q[i];
            busy_d = busy_d | (active_q[i] != target_q[i]);
            if (sel_hit[i]) rd_d = active_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            pwm         <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            rd_width    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                target_q[i] <= INIT_V;
                active_q[i] <= INIT_V;
            end
        end else begin
            count_q     <= frame_end ? '0 : count_q + 1'b1;
            frame_start <= (count_q == '0);
            busy        <= busy_d;
            rd_width    <= rd_d;
            for (int i = 0; i < N_CH; i++) begin
                pwm[i]      <= enable[i] && (count_q < active_q[i]);
                target_q[i] <= target_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: table-driven target updates plus frame-level width, slew,
// enable and reset sequences, with expected widths queued ahead of each observation.
module tb_servo_pwm_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] enable;
    logic [1:0] sel;
    logic       inc, dec, wr_en;
    logic [7:0] wr_data;
    logic [3:0] pwm, pwm2;
    logic       fs, fs2, busy, busy2;
    logic [7:0] rdw, rdw2;

    servo_pwm_multi #(
        .N_CH(4), .CW(8), .PERIOD(100), .PULSE_MIN(10), .PULSE_MAX(50),
        .PULSE_INIT(30), .STEP(5), .SLEW(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sel(sel), .inc(inc), .dec(dec),
        .wr_en(wr_en), .wr_data(wr_data), .pwm(pwm), .frame_start(fs), .busy(busy),
        .rd_width(rdw)
    );

    servo_pwm_multi #(
        .N_CH(4), .CW(8), .PERIOD(100), .PULSE_MIN(10), .PULSE_MAX(50),
        .PULSE_INIT(30), .STEP(5), .SLEW(4)
    ) dut_slew (
        .clk(clk), .rst(rst), .enable(enable), .sel(sel), .inc(inc), .dec(dec),
        .wr_en(wr_en), .wr_data(wr_data), .pwm(pwm2), .frame_start(fs2), .busy(busy2),
        .rd_width(rdw2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       wr;
        logic       inc;
        logic       dec;
        logic [7:0] data;
        int         exp;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next negedge on which the selected DUT shows frame_start.
    task automatic wait_fs(input bit which);
        int k = 0;
        logic f;
        do begin
            @(negedge clk);
            k++;
            f = which ? fs2 : fs;
        end while (f !== 1'b1 && k < 300);
        if (f !== 1'b1) check("frame_start_timeout", {31'b0, f}, 1);
    endtask

    // Starts on a frame_start negedge; ends on the next one. Optional write at offset wr_at.
    task automatic measure_frame(input int wr_at, input logic [1:0] wsel, input logic [7:0] wdata);
        int hi[4];
        int fs_cnt = 0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int k = 0; k < 100; k++) begin
            for (int c = 0; c < 4; c++) hi[c] += (pwm[c] === 1'b1) ? 1 : 0;
            fs_cnt += (fs === 1'b1) ? 1 : 0;
            if (k == wr_at) begin
                sel = wsel; wr_data = wdata; wr_en = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("frame_period", {31'b0, fs}, 1);
        check("frame_start_once", fs_cnt, 1);
        for (int c = 0; c < 4; c++) begin
            int e;
            e = exp_q.pop_front();
            check($sformatf("width_ch%0d", c), hi[c], e);
        end
    endtask

    task automatic push_widths(input int w0, input int w1, input int w2, input int w3);
        exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
    endtask

    initial begin
        rst = 1'b1; enable = 4'hF; sel = '0; inc = 0; dec = 0; wr_en = 0; wr_data = '0;

        // Vector table: cumulative target sequences, observed through rd_width a frame later.
        vecs.push_back('{2'd0, 1'b0, 1'b1, 1'b0, 8'd0,   35});
        vecs.push_back('{2'd0, 1'b0, 1'b1, 1'b0, 8'd0,   40});
        vecs.push_back('{2'd0, 1'b0, 1'b1, 1'b0, 8'd0,   45});
        vecs.push_back('{2'd0, 1'b0, 1'b1, 1'b0, 8'd0,   50});
        vecs.push_back('{2'd0, 1'b0, 1'b1, 1'b0, 8'd0,   50});
        vecs.push_back('{2'd0, 1'b1, 1'b0, 1'b0, 8'd3,   10});
        vecs.push_back('{2'd0, 1'b1, 1'b0, 1'b0, 8'd200, 50});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b1, 8'd0,   45});
        vecs.push_back('{2'd1, 1'b1, 1'b1, 1'b1, 8'd20,  20});
        vecs.push_back('{2'd3, 1'b0, 1'b1, 1'b1, 8'd0,   35});
        vecs.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 8'd12,  12});
        vecs.push_back('{2'd1, 1'b0, 1'b0, 1'b1, 8'd0,   10});
        vecs.push_back('{2'd1, 1'b0, 1'b0, 1'b1, 8'd0,   10});
        vecs.push_back('{2'd2, 1'b0, 1'b0, 1'b1, 8'd0,   40});

        repeat (3) @(negedge clk);
        check("reset_pwm", pwm, 0);
        check("reset_frame_start", {31'b0, fs}, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_rd_width", rdw, 0);
        rst = 1'b0;

        // All channels at the initial width; then a mid-frame write on ch2.
        wait_fs(0);
        check("idle_busy", {31'b0, busy}, 0);
        push_widths(30, 30, 30, 30);
        measure_frame(-1, 2'd0, 8'd0);
        push_widths(30, 30, 30, 30);
        measure_frame(10, 2'd2, 8'd45);
        push_widths(30, 30, 45, 30);
        measure_frame(-1, 2'd0, 8'd0);

        foreach (vecs[v]) begin
            sel = vecs[v].sel; wr_en = vecs[v].wr; inc = vecs[v].inc; dec = vecs[v].dec;
            wr_data = vecs[v].data;
            exp_q.push_back(vecs[v].exp);
            @(negedge clk);
            wr_en = 0; inc = 0; dec = 0;
            wait_fs(0);
            check($sformatf("vec%0d_rd_width", v), rdw, exp_q.pop_front());
        end

        // Slew-limited channel: 30 -> 50 in steps of 4 per frame.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; sel = 2'd0; wr_data = 8'd50; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        check("slew_busy_start", {31'b0, busy2}, 1);
        for (int w = 34; w <= 50; w += 4) begin
            wait_fs(1);
            exp_q.push_back(w);
            check($sformatf("slew_width_%0d", w), rdw2, exp_q.pop_front());
            check($sformatf("slew_busy_%0d", w), {31'b0, busy2}, (w != 50) ? 1 : 0);
        end

        // Enable drop / resume mid-pulse, then reset mid-frame.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; sel = 2'd3;
        wait_fs(0);
        check("en_pulse_start", pwm, 4'hF);
        repeat (5) @(negedge clk);
        enable = 4'h7;
        @(negedge clk);
        check("disable_ch3", {31'b0, pwm[3]}, 0);
        check("others_on", {29'b0, pwm[2:0]}, 7);
        repeat (3) @(negedge clk);
        enable = 4'hF;
        @(negedge clk);
        check("reenable_ch3", {31'b0, pwm[3]}, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_pwm", pwm, 0);
        check("midreset_rd_width", rdw, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_frame_start", {31'b0, fs}, 1);
        check("restart_rd_width", rdw, 30);
        push_widths(30, 30, 30, 30);
        measure_frame(-1, 2'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
